// File: rtl/hazard_control_unit_if.sv
// Signal bundle between the hazard controller and the pipeline it gates.
// Inputs are sampled combinationally; there is no valid/ready handshake, every signal is meaningful every cycle.
interface hazard_control_unit_if #(
  parameter int CNT_W = 32
);
  logic             memread_ex;
  logic [4:0]       rd_ex;
  logic [4:0]       rs1_id;
  logic [4:0]       rs2_id;
  logic             use_rs1_id;
  logic             use_rs2_id;
  logic             to_branch_mem;

  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             stall_active;
  logic [CNT_W-1:0] cnt_cycles;
  logic [CNT_W-1:0] cnt_stalls;
  logic [CNT_W-1:0] cnt_flushes;

  // Debug view of the controller FSM (0 = RUN, 1 = STALL) and its remaining-cycle counter.
  logic             dbg_state;
  logic [2:0]       dbg_rem;

  modport master (
    output memread_ex, rd_ex, rs1_id, rs2_id, use_rs1_id, use_rs2_id, to_branch_mem,
    input  pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, stall_active,
    input  cnt_cycles, cnt_stalls, cnt_flushes, dbg_state, dbg_rem
  );

  modport slave (
    input  memread_ex, rd_ex, rs1_id, rs2_id, use_rs1_id, use_rs2_id, to_branch_mem,
    output pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, stall_active,
    output cnt_cycles, cnt_stalls, cnt_flushes, dbg_state, dbg_rem
  );
endinterface

// File: rtl/hazard_control_unit.sv
// Load-use stall and taken-branch flush controller for the 5-stage core, with saturating perf counters.
// Control outputs are combinational so they gate the same edge that loads the pipeline registers.
module hazard_control_unit #(
  parameter int LOAD_STALL_CYCLES = 2,
  parameter int CNT_W             = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  hazard_control_unit_if.slave bus
);
  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  localparam logic [2:0] REM_INIT = 3'(LOAD_STALL_CYCLES - 1);

  state_t           r_state;
  logic [2:0]       r_rem;
  logic [CNT_W-1:0] r_cnt_cycles;
  logic [CNT_W-1:0] r_cnt_stalls;
  logic [CNT_W-1:0] r_cnt_flushes;

  state_t     w_next_state;
  logic [2:0] w_next_rem;
  logic       w_haz;
  logic       w_pc_write;
  logic       w_ifid_write;
  logic       w_ifid_flush;
  logic       w_idex_flush;
  logic       w_exmem_flush;

  assign w_haz = bus.memread_ex && (bus.rd_ex != 5'd0) &&
                 ((bus.use_rs1_id && (bus.rd_ex == bus.rs1_id)) ||
                  (bus.use_rs2_id && (bus.rd_ex == bus.rs2_id)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RUN;
      r_rem   <= 3'd0;
    end else begin
      r_state <= w_next_state;
      r_rem   <= w_next_rem;
    end
  end

  // Reset gating keeps the pipe free-running while reset is low, even if haz or a branch is presented.
  always_comb begin
    w_next_state  = r_state;
    w_next_rem    = r_rem;
    w_pc_write    = 1'b1;
    w_ifid_write  = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_flush  = 1'b0;
    w_exmem_flush = 1'b0;
    if (!reset) begin
      w_next_state = RUN;
      w_next_rem   = 3'd0;
    end else if (bus.to_branch_mem) begin
      w_ifid_flush  = 1'b1;
      w_idex_flush  = 1'b1;
      w_exmem_flush = 1'b1;
      w_next_state  = RUN;
      w_next_rem    = 3'd0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_haz) begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_idex_flush = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              w_next_state = STALL;
              w_next_rem   = REM_INIT;
            end
          end
        end
        STALL: begin
          w_pc_write   = 1'b0;
          w_ifid_write = 1'b0;
          w_idex_flush = 1'b1;
          if (r_rem <= 3'd1) begin
            w_next_state = RUN;
            w_next_rem   = 3'd0;
          end else begin
            w_next_rem = r_rem - 3'd1;
          end
        end
        default: begin
          w_next_state = RUN;
          w_next_rem   = 3'd0;
        end
      endcase
    end
  end

  // Counters stop at all-ones instead of wrapping so long runs never report small values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt_cycles  <= '0;
      r_cnt_stalls  <= '0;
      r_cnt_flushes <= '0;
    end else begin
      if (r_cnt_cycles != '1)
        r_cnt_cycles <= r_cnt_cycles + CNT_W'(1);
      if (!w_pc_write && (r_cnt_stalls != '1))
        r_cnt_stalls <= r_cnt_stalls + CNT_W'(1);
      if (bus.to_branch_mem && (r_cnt_flushes != '1))
        r_cnt_flushes <= r_cnt_flushes + CNT_W'(1);
    end
  end

  assign bus.pc_write     = w_pc_write;
  assign bus.ifid_write   = w_ifid_write;
  assign bus.ifid_flush   = w_ifid_flush;
  assign bus.idex_flush   = w_idex_flush;
  assign bus.exmem_flush  = w_exmem_flush;
  assign bus.stall_active = ~w_pc_write;
  assign bus.cnt_cycles   = r_cnt_cycles;
  assign bus.cnt_stalls   = r_cnt_stalls;
  assign bus.cnt_flushes  = r_cnt_flushes;
  assign bus.dbg_state    = r_state;
  assign bus.dbg_rem      = r_rem;
endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: four builds (hold 2, 1, 3 and a 4-bit-counter build) share one stimulus
// stream and are checked every cycle against a remaining-hold-count reference model.
module tb_hazard_control_unit;
  logic       clk = 1'b0;
  logic       reset;
  logic       memread_ex;
  logic [4:0] rd_ex;
  logic [4:0] rs1_id;
  logic [4:0] rs2_id;
  logic       use_rs1_id;
  logic       use_rs2_id;
  logic       to_branch_mem;

  always #5 clk = ~clk;

  hazard_control_unit_if #(.CNT_W(32)) if_a ();
  hazard_control_unit_if #(.CNT_W(32)) if_b ();
  hazard_control_unit_if #(.CNT_W(32)) if_c ();
  hazard_control_unit_if #(.CNT_W(4))  if_d ();

  assign if_a.memread_ex = memread_ex; assign if_a.rd_ex = rd_ex; assign if_a.rs1_id = rs1_id;
  assign if_a.rs2_id = rs2_id; assign if_a.use_rs1_id = use_rs1_id; assign if_a.use_rs2_id = use_rs2_id;
  assign if_a.to_branch_mem = to_branch_mem;
  assign if_b.memread_ex = memread_ex; assign if_b.rd_ex = rd_ex; assign if_b.rs1_id = rs1_id;
  assign if_b.rs2_id = rs2_id; assign if_b.use_rs1_id = use_rs1_id; assign if_b.use_rs2_id = use_rs2_id;
  assign if_b.to_branch_mem = to_branch_mem;
  assign if_c.memread_ex = memread_ex; assign if_c.rd_ex = rd_ex; assign if_c.rs1_id = rs1_id;
  assign if_c.rs2_id = rs2_id; assign if_c.use_rs1_id = use_rs1_id; assign if_c.use_rs2_id = use_rs2_id;
  assign if_c.to_branch_mem = to_branch_mem;
  assign if_d.memread_ex = memread_ex; assign if_d.rd_ex = rd_ex; assign if_d.rs1_id = rs1_id;
  assign if_d.rs2_id = rs2_id; assign if_d.use_rs1_id = use_rs1_id; assign if_d.use_rs2_id = use_rs2_id;
  assign if_d.to_branch_mem = to_branch_mem;

  hazard_control_unit #(.LOAD_STALL_CYCLES(2), .CNT_W(32)) dut_l2 (.clk(clk), .reset(reset), .bus(if_a.slave));
  hazard_control_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(32)) dut_l1 (.clk(clk), .reset(reset), .bus(if_b.slave));
  hazard_control_unit #(.LOAD_STALL_CYCLES(3), .CNT_W(32)) dut_l3 (.clk(clk), .reset(reset), .bus(if_c.slave));
  hazard_control_unit #(.LOAD_STALL_CYCLES(2), .CNT_W(4))  dut_c4 (.clk(clk), .reset(reset), .bus(if_d.slave));

  // {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, stall_active}
  logic [5:0]  obs_ctl [4];
  logic [31:0] obs_cyc [4];
  logic [31:0] obs_stl [4];
  logic [31:0] obs_fl  [4];

  assign obs_ctl[0] = {if_a.pc_write, if_a.ifid_write, if_a.ifid_flush, if_a.idex_flush, if_a.exmem_flush, if_a.stall_active};
  assign obs_ctl[1] = {if_b.pc_write, if_b.ifid_write, if_b.ifid_flush, if_b.idex_flush, if_b.exmem_flush, if_b.stall_active};
  assign obs_ctl[2] = {if_c.pc_write, if_c.ifid_write, if_c.ifid_flush, if_c.idex_flush, if_c.exmem_flush, if_c.stall_active};
  assign obs_ctl[3] = {if_d.pc_write, if_d.ifid_write, if_d.ifid_flush, if_d.idex_flush, if_d.exmem_flush, if_d.stall_active};
  assign obs_cyc[0] = if_a.cnt_cycles;  assign obs_stl[0] = if_a.cnt_stalls;  assign obs_fl[0] = if_a.cnt_flushes;
  assign obs_cyc[1] = if_b.cnt_cycles;  assign obs_stl[1] = if_b.cnt_stalls;  assign obs_fl[1] = if_b.cnt_flushes;
  assign obs_cyc[2] = if_c.cnt_cycles;  assign obs_stl[2] = if_c.cnt_stalls;  assign obs_fl[2] = if_c.cnt_flushes;
  assign obs_cyc[3] = 32'(if_d.cnt_cycles); assign obs_stl[3] = 32'(if_d.cnt_stalls); assign obs_fl[3] = 32'(if_d.cnt_flushes);

  localparam logic [5:0] CTL_PASS  = 6'b110000;
  localparam logic [5:0] CTL_HOLD  = 6'b000101;
  localparam logic [5:0] CTL_FLUSH = 6'b111110;

  int              hold_cycles [4] = '{2, 1, 3, 2};
  longint unsigned cnt_max     [4] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};
  int              hold_left   [4];
  longint unsigned m_cyc [4];
  longint unsigned m_stl [4];
  longint unsigned m_fl  [4];
  int checks = 0;
  int errors = 0;

  function automatic logic haz_now();
    return memread_ex && (rd_ex != 5'd0) &&
           ((use_rs1_id && rd_ex == rs1_id) || (use_rs2_id && rd_ex == rs2_id));
  endfunction

  function automatic logic [5:0] exp_ctl(int i);
    if (!reset) return CTL_PASS;
    if (to_branch_mem) return CTL_FLUSH;
    if (hold_left[i] > 0 || haz_now()) return CTL_HOLD;
    return CTL_PASS;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      hold_left[i] = 0; m_cyc[i] = 0; m_stl[i] = 0; m_fl[i] = 0;
    end
  endtask

  function automatic longint unsigned sat_inc(longint unsigned v, longint unsigned mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic check_point(string tag);
    for (int i = 0; i < 4; i++) begin
      logic [5:0] e;
      e = exp_ctl(i);
      checks++;
      assert (obs_ctl[i] === e) else begin
        errors++; $error("FAIL %s dut%0d ctl got %b exp %b", tag, i, obs_ctl[i], e);
      end
      checks++;
      assert (obs_cyc[i] === 32'(m_cyc[i])) else begin
        errors++; $error("FAIL %s dut%0d cnt_cycles got %0d exp %0d", tag, i, obs_cyc[i], m_cyc[i]);
      end
      checks++;
      assert (obs_stl[i] === 32'(m_stl[i])) else begin
        errors++; $error("FAIL %s dut%0d cnt_stalls got %0d exp %0d", tag, i, obs_stl[i], m_stl[i]);
      end
      checks++;
      assert (obs_fl[i] === 32'(m_fl[i])) else begin
        errors++; $error("FAIL %s dut%0d cnt_flushes got %0d exp %0d", tag, i, obs_fl[i], m_fl[i]);
      end
    end
  endtask

  // Called just after a falling edge with inputs already set: check, clock once, advance the model.
  task automatic step(string tag);
    logic [5:0] pre [4];
    logic       br;
    logic       h;
    #1;
    check_point(tag);
    for (int i = 0; i < 4; i++) pre[i] = exp_ctl(i);
    br = to_branch_mem;
    h  = haz_now();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        if (br) hold_left[i] = 0;
        else if (hold_left[i] > 0) hold_left[i]--;
        else if (h) hold_left[i] = hold_cycles[i] - 1;
        m_cyc[i] = sat_inc(m_cyc[i], cnt_max[i]);
        if (pre[i][0]) m_stl[i] = sat_inc(m_stl[i], cnt_max[i]);
        if (br) m_fl[i] = sat_inc(m_fl[i], cnt_max[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic set_in(logic mr, logic [4:0] rd, logic [4:0] r1, logic [4:0] r2,
                        logic u1, logic u2, logic br);
    memread_ex = mr; rd_ex = rd; rs1_id = r1; rs2_id = r2;
    use_rs1_id = u1; use_rs2_id = u2; to_branch_mem = br;
  endtask

  initial begin
    model_clear();
    reset = 1'b0;
    // Hazard and branch presented during reset must not leak to the outputs.
    set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1);
    #3;
    check_point("reset_outputs");
    @(negedge clk);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    step("release_cyc0");
    step("release_cyc1");

    // lw x5; add x6,x5,x1 -- consumer held, bubble then reaches EX.
    set_in(1'b1, 5'd5, 5'd5, 5'd1, 1'b1, 1'b1, 1'b0);
    step("loaduse_rs1_detect");
    set_in(1'b0, 5'd6, 5'd5, 5'd1, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) step("loaduse_rs1_hold");

    set_in(1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0);
    step("no_haz_rs2_unused");
    set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    step("no_haz_rd_x0");
    set_in(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b1, 1'b0);
    step("loaduse_rs2_detect");
    for (int k = 0; k < 4; k++) step("back_to_back");

    set_in(1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1);
    step("branch_in_detect");
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    step("after_branch");

    set_in(1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0);
    step("stall_then_branch");
    set_in(1'b0, 5'd0, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1);
    step("branch_in_stall");
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    step("after_branch_in_stall");

    // Reset asserted while the hold-2 and hold-3 builds are mid-stall.
    set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
    step("pre_reset_detect");
    set_in(1'b0, 5'd0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    check_point("reset_mid_stall");
    @(negedge clk);
    reset = 1'b1;
    step("rerelease_cyc0");
    step("rerelease_cyc1");

    for (int k = 0; k < 150; k++) begin
      set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 7) == 0));
      step("random");
    end

    checks++;
    assert (obs_cyc[3] === 32'd15) else begin
      errors++; $error("FAIL sat_cnt4 cnt_cycles got %0d exp 15", obs_cyc[3]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
